// File: rtl/ws_tile_sequencer_if.sv
// Host command / array control bundle for the weight-stationary tile sequencer.
// The master side issues commands and the slave side (the sequencer) drives the array and buffer controls.
interface ws_tile_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int KT_W   = 4,
  parameter int ML_W   = 8
);
  // Handshake: start is a one-cycle command strobe taken only while busy=0.
  // There is no ready: a start seen while busy is dropped, not queued.
  // abort is a level sampled every cycle, and it cancels a running job.
  logic              start;
  logic              abort;
  logic [KT_W-1:0]   num_k_tiles;
  logic [ML_W-1:0]   m_len;
  logic              busy;
  logic              done;
  logic              err;
  logic              arr_en;
  logic              arr_data_flow;
  logic              arr_load;
  logic              arr_acc_en;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;

  modport master (
    output start, abort, num_k_tiles, m_len,
    input  busy, done, err, arr_en, arr_data_flow, arr_load, arr_acc_en,
           w_rd_en, w_rd_addr, a_rd_en, a_rd_addr
  );

  modport slave (
    input  start, abort, num_k_tiles, m_len,
    output busy, done, err, arr_en, arr_data_flow, arr_load, arr_acc_en,
           w_rd_en, w_rd_addr, a_rd_en, a_rd_addr
  );
endinterface

// File: rtl/ws_tile_sequencer.sv
// Weight-stationary sequencer: for each of K tiles it loads ROWS weight rows,
// then streams m_len A rows and flushes the array for ROWS+COLS-1 cycles.
module ws_tile_sequencer #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 10,
  parameter int KT_W   = 4,
  parameter int ML_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ws_tile_sequencer_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int FLUSH = ROWS + COLS - 1;
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam int CNT_W = $clog2((1 << ML_W) + FLUSH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_W  = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [KT_W-1:0]   tile_q, tile_d;
  logic [KT_W-1:0]   k_q, k_d;
  logic [ML_W-1:0]   m_q, m_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              arr_en_q, arr_en_d;
  logic              arr_load_q, arr_load_d;
  logic              acc_en_q, acc_en_d;
  logic              w_rd_en_q, w_rd_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic              a_rd_en_q, a_rd_en_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;

  logic              done_pulse;
  logic              err_pulse;
  logic [CNT_W-1:0]  last_cnt;

  assign last_cnt = CNT_W'(m_q) + CNT_W'(FLUSH - 1);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    tile_d     = tile_q;
    k_d        = k_q;
    m_d        = m_q;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.m_len == '0) begin
            err_pulse = 1'b1;
          end else if (bus.num_k_tiles == '0) begin
            done_pulse = 1'b1;
          end else begin
            state_d = S_LOAD_W;
            row_d   = '0;
            cnt_d   = '0;
            tile_d  = '0;
            k_d     = bus.num_k_tiles;
            m_d     = bus.m_len;
          end
        end
      end
      S_LOAD_W: begin
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt_q == last_cnt) begin
          if (tile_q == k_q - KT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            // Next tile starts loading immediately, no idle gap.
            state_d = S_LOAD_W;
            tile_d  = tile_q + KT_W'(1);
            row_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      row_d   = '0;
      cnt_d   = '0;
      tile_d  = '0;
      k_d     = '0;
      m_d     = '0;
    end
  end

  // Outputs decode the next state so they line up with it after the edge.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = done_pulse || (state_d == S_DONE);
    err_d      = err_pulse;
    arr_en_d   = (state_d == S_LOAD_W) || (state_d == S_COMPUTE);
    arr_load_d = (state_d == S_LOAD_W);
    w_rd_en_d  = (state_d == S_LOAD_W);
    acc_en_d   = (state_d == S_COMPUTE) && (tile_d != '0);
    a_rd_en_d  = (state_d == S_COMPUTE) && (cnt_d < CNT_W'(m_d));
    w_addr_d   = '0;
    a_addr_d   = '0;
    if (w_rd_en_d) begin
      w_addr_d = ADDR_W'(tile_d) * ADDR_W'(ROWS) + ADDR_W'(row_d);
    end
    if (a_rd_en_d) begin
      a_addr_d = ADDR_W'(tile_d) * ADDR_W'(m_d) + ADDR_W'(cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      cnt_q      <= '0;
      tile_q     <= '0;
      k_q        <= '0;
      m_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      arr_en_q   <= 1'b0;
      arr_load_q <= 1'b0;
      acc_en_q   <= 1'b0;
      w_rd_en_q  <= 1'b0;
      w_addr_q   <= '0;
      a_rd_en_q  <= 1'b0;
      a_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      tile_q     <= tile_d;
      k_q        <= k_d;
      m_q        <= m_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      arr_en_q   <= arr_en_d;
      arr_load_q <= arr_load_d;
      acc_en_q   <= acc_en_d;
      w_rd_en_q  <= w_rd_en_d;
      w_addr_q   <= w_addr_d;
      a_rd_en_q  <= a_rd_en_d;
      a_addr_q   <= a_addr_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.arr_en        = arr_en_q;
  assign bus.arr_data_flow = 1'b1;
  assign bus.arr_load      = arr_load_q;
  assign bus.arr_acc_en    = acc_en_q;
  assign bus.w_rd_en       = w_rd_en_q;
  assign bus.w_rd_addr     = w_addr_q;
  assign bus.a_rd_en       = a_rd_en_q;
  assign bus.a_rd_addr     = a_addr_q;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_ws_tile_sequencer.sv
// Bench for ws_tile_sequencer: a job-level table, random jobs checked cycle by cycle
// against a trace model, plus directed abort, start-while-busy and reset sequences.
module tb_ws_tile_sequencer;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int ADDR_W = 10;
  localparam int KT_W   = 4;
  localparam int ML_W   = 8;
  localparam int FLUSH  = ROWS + COLS - 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_err;

  ws_tile_sequencer_if #(.ADDR_W(ADDR_W), .KT_W(KT_W), .ML_W(ML_W)) bus ();

  ws_tile_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .KT_W(KT_W), .ML_W(ML_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- trace model ----------------
  typedef struct packed {
    logic              busy;
    logic              done;
    logic              err;
    logic              en;
    logic              load;
    logic              acc;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic              a_en;
    logic [ADDR_W-1:0] a_addr;
    logic              df;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic cyc_t idle_cyc();
    cyc_t c;
    c    = '0;
    c.df = 1'b1;
    return c;
  endfunction

  // Whole job expressed as a flat list of per-cycle expectations.
  function automatic void build_exp(input int k, input int m);
    cyc_t c;
    exp_q.delete();
    for (int t = 0; t < k; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        c        = idle_cyc();
        c.busy   = 1'b1;
        c.en     = 1'b1;
        c.load   = 1'b1;
        c.w_en   = 1'b1;
        c.w_addr = ADDR_W'(t * ROWS + r);
        exp_q.push_back(c);
      end
      for (int i = 0; i < m + FLUSH; i++) begin
        c      = idle_cyc();
        c.busy = 1'b1;
        c.en   = 1'b1;
        c.acc  = (t != 0);
        if (i < m) begin
          c.a_en   = 1'b1;
          c.a_addr = ADDR_W'(t * m + i);
        end
        exp_q.push_back(c);
      end
    end
    c      = idle_cyc();
    c.busy = 1'b1;
    c.done = 1'b1;
    exp_q.push_back(c);
    exp_q.push_back(idle_cyc());
  endfunction

  // Addresses only matter while their strobe is high; acc_en only while computing.
  function automatic cyc_t sample();
    cyc_t s;
    s.busy   = bus.busy;
    s.done   = bus.done;
    s.err    = bus.err;
    s.en     = bus.arr_en;
    s.load   = bus.arr_load;
    s.acc    = (bus.arr_en && !bus.arr_load) ? bus.arr_acc_en : 1'b0;
    s.w_en   = bus.w_rd_en;
    s.w_addr = bus.w_rd_en ? bus.w_rd_addr : '0;
    s.a_en   = bus.a_rd_en;
    s.a_addr = bus.a_rd_en ? bus.a_rd_addr : '0;
    s.df     = bus.arr_data_flow;
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic cmp_cyc(input string nm, input cyc_t act, input cyc_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_start(input int k, input int m);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_k_tiles = KT_W'(k);
    bus.m_len       = ML_W'(m);
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.num_k_tiles = KT_W'($urandom);
    bus.m_len       = ML_W'($urandom);
  endtask

  // start_at / abort_at index the expected trace; -1 disables them.
  task automatic run_job(input int k, input int m, input int start_at,
                         input int abort_at, output int cyc);
    cyc_t e;
    cyc_t a;
    int   idx;
    bit   seen_done;
    build_exp(k, m);
    cyc       = 0;
    seen_done = 1'b0;
    idx       = 0;
    issue_start(k, m);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      a = sample();
      if (!seen_done && a.busy) cyc++;
      if (a.done) seen_done = 1'b1;
      cmp_cyc($sformatf("job k%0d m%0d cyc%0d", k, m, idx), a, e);
      if (idx == start_at) begin
        bus.start       = 1'b1;
        bus.num_k_tiles = KT_W'(1);
        bus.m_len       = ML_W'(1);
      end else begin
        bus.start = 1'b0;
      end
      if (idx == abort_at) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        cmp_cyc("abort next cycle", sample(), idle_cyc());
        exp_q.delete();
      end
      idx++;
    end
  endtask

  task automatic run_bad(input int k, input int m, input bit e_err, input bit e_done);
    issue_start(k, m);
    @(negedge clk);
    chk($sformatf("bad k%0d m%0d err", k, m), bus.err, e_err);
    chk($sformatf("bad k%0d m%0d done", k, m), bus.done, e_done);
    chk($sformatf("bad k%0d m%0d busy", k, m), bus.busy, 0);
    chk($sformatf("bad k%0d m%0d arr_en", k, m), bus.arr_en, 0);
    @(negedge clk);
    cmp_cyc($sformatf("bad k%0d m%0d after", k, m), sample(), idle_cyc());
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int k;
    int m;
    int exp_cycles;
    bit exp_err;
    bit exp_done0;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cyc;
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{1, 4, 28, 1'b0, 1'b0};
    tbl[1] = '{3, 4, 82, 1'b0, 1'b0};
    tbl[2] = '{2, 1, 49, 1'b0, 1'b0};
    tbl[3] = '{1, 1, 25, 1'b0, 1'b0};
    tbl[4] = '{0, 5, 0, 1'b0, 1'b1};
    tbl[5] = '{5, 0, 0, 1'b1, 1'b0};
    tbl[6] = '{0, 0, 0, 1'b1, 1'b0};

    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.num_k_tiles = '0;
    bus.m_len       = '0;
    #3;
    cmp_cyc("reset state", sample(), idle_cyc());
    chk("reset w_rd_addr", bus.w_rd_addr, 0);
    chk("reset a_rd_addr", bus.a_rd_addr, 0);
    chk("reset acc_en", bus.arr_acc_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].exp_err || tbl[i].exp_done0) begin
        run_bad(tbl[i].k, tbl[i].m, tbl[i].exp_err, tbl[i].exp_done0);
      end else begin
        run_job(tbl[i].k, tbl[i].m, -1, -1, cyc);
        chk($sformatf("table k%0d m%0d cycles", tbl[i].k, tbl[i].m), cyc, tbl[i].exp_cycles);
      end
    end

    // abort in tile 1, COMPUTE cycle 2: trace index 27 + 8 + 2
    run_job(3, 4, -1, 37, cyc);
    repeat (3) begin
      @(negedge clk);
      cmp_cyc("post-abort idle", sample(), idle_cyc());
    end
    run_job(2, 3, -1, -1, cyc);
    chk("job after abort cycles", cyc, 2 * (ROWS + 3 + FLUSH) + 1);

    // start during LOAD_W of a running job is ignored
    run_job(3, 4, 3, -1, cyc);
    chk("start-while-busy cycles", cyc, 82);

    // abort in IDLE is a no-op, and abort beats a simultaneous start
    @(negedge clk);
    bus.abort       = 1'b1;
    bus.start       = 1'b1;
    bus.num_k_tiles = KT_W'(2);
    bus.m_len       = ML_W'(3);
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    cmp_cyc("abort+start in idle", sample(), idle_cyc());
    @(negedge clk);
    cmp_cyc("abort+start in idle later", sample(), idle_cyc());

    // address wrap at ADDR_W bits
    run_job(15, 200, -1, -1, cyc);
    chk("wrap job cycles", cyc, 15 * (ROWS + 200 + FLUSH) + 1);

    // async reset mid-COMPUTE
    issue_start(2, 6);
    repeat (12) @(negedge clk);
    chk("pre-reset arr_en", bus.arr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp_cyc("async reset outputs", sample(), idle_cyc());
    chk("async reset dbg_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(1, 4, -1, -1, cyc);
    chk("job after reset cycles", cyc, 28);

    // random jobs
    for (int j = 0; j < 12; j++) begin
      int k;
      int m;
      int s_at;
      k    = $urandom_range(1, 4);
      m    = $urandom_range(1, 24);
      s_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, ROWS - 1) : -1;
      run_job(k, m, s_at, -1, cyc);
      chk($sformatf("rand k%0d m%0d cycles", k, m), cyc, k * (ROWS + m + FLUSH) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
